// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request bus between the fetch sequencer
// and the wait-stated instruction memory.
interface if_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC, talks to imem and
// buffers fetched words in a 2-entry queue feeding IF/ID.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_addr,
    if_fetch_ctrl_if.master       imem,
    output logic                  out_valid,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_instr
);

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        DROP       = 2'd1,
        WAIT_SPACE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
    logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;

    logic        xfer;
    logic        pop;
    logic        push;
    logic [31:0] nxt_pc;

    // A request is live in FETCH and DROP; never during reset.
    assign imem.imem_req  = !rst && (state_q != WAIT_SPACE);
    assign imem.imem_addr = pc_q;

    assign xfer   = imem.imem_req && imem.imem_ready;
    assign pop    = (cnt_q != 2'd0) && !freeze;
    assign push   = (state_q == FETCH) && xfer && !branch_taken;
    assign nxt_pc = pc_q + PC_INC;

    assign out_valid = (cnt_q != 2'd0);
    assign out_pc    = pc0_q;
    assign out_instr = ins0_q;

    // Queue update: a redirect empties the queue outright.
    always_comb begin
        cnt_d  = cnt_q;
        pc0_d  = pc0_q;
        ins0_d = ins0_q;
        pc1_d  = pc1_q;
        ins1_d = ins1_q;
        if (branch_taken) begin
            cnt_d = 2'd0;
        end else if (push && pop) begin
            if (cnt_q == 2'd2) begin
                pc0_d  = pc1_q;
                ins0_d = ins1_q;
                pc1_d  = nxt_pc;
                ins1_d = imem.imem_rdata;
            end else begin
                pc0_d  = nxt_pc;
                ins0_d = imem.imem_rdata;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                pc0_d  = nxt_pc;
                ins0_d = imem.imem_rdata;
            end else begin
                pc1_d  = nxt_pc;
                ins1_d = imem.imem_rdata;
            end
            cnt_d = cnt_q + 2'd1;
        end else if (pop) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            cnt_d  = cnt_q - 2'd1;
        end
    end

    // Sequencer next state, PC and pending redirect target.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            FETCH: begin
                if (xfer && branch_taken) begin
                    pc_d = branch_addr;
                end else if (branch_taken) begin
                    tgt_d   = branch_addr;
                    state_d = DROP;
                end else if (xfer) begin
                    pc_d = nxt_pc;
                    if (cnt_d == 2'd2) begin
                        state_d = WAIT_SPACE;
                    end
                end
            end
            DROP: begin
                if (xfer) begin
                    pc_d    = branch_taken ? branch_addr : tgt_q;
                    state_d = FETCH;
                end else if (branch_taken) begin
                    tgt_d = branch_addr;
                end
            end
            WAIT_SPACE: begin
                if (branch_taken) begin
                    pc_d    = branch_addr;
                    state_d = FETCH;
                end else if (pop) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, PC and queue registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            cnt_q   <= 2'd0;
            pc0_q   <= 32'h0;
            ins0_q  <= 32'h0;
            pc1_q   <= 32'h0;
            ins1_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            pc0_q   <= pc0_d;
            ins0_q  <= ins0_d;
            pc1_q   <= pc1_d;
            ins1_q  <= ins1_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized scoreboard bench for if_fetch_ctrl: expected
// instruction stream is rebuilt at every redirect or reset.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(
        .RESET_PC (RPC),
        .PC_INC   (32'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (bus),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] sb_next;

    int checks   = 0;
    int failures = 0;
    int consumed = 0;

    int  wmax, fz_pct, br_pct, rst_pct, rst_left, wl;
    bit  full_rate;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    task automatic topup();
        exp_t e;
        while (sb.size() < 8) begin
            e.pc  = sb_next + 32'd4;
            e.ins = memf(sb_next);
            sb.push_back(e);
            sb_next = sb_next + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        sb.delete();
        sb_next = a;
        topup();
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0: t = 32'hFFFF_FFF0 + 32'd4 * $urandom_range(3);
            1: t = 32'h40 + 32'd4 * $urandom_range(15);
            default: t = $urandom & 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    // One stimulus cycle, applied 2 time units after posedge.
    task automatic cycle();
        @(posedge clk);
        #2;
        if (bus.imem_req) begin
            if (wl == 0) begin
                bus.imem_ready = 1'b1;
                bus.imem_rdata = memf(bus.imem_addr);
                wl = $urandom_range(wmax);
            end else begin
                bus.imem_ready = 1'b0;
                bus.imem_rdata = $urandom;
                wl--;
            end
        end else begin
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
        end
        if (rst_left > 0) begin
            rst = 1'b1;
            rst_left--;
        end else if (rst_pct != 0 && $urandom_range(99) < rst_pct) begin
            rst = 1'b1;
            rst_left = $urandom_range(2);
        end else begin
            rst = 1'b0;
        end
        if (rst) begin
            branch_taken = 1'b0;
            restart(RPC);
        end else begin
            branch_taken = ($urandom_range(99) < br_pct);
            if (branch_taken) begin
                branch_addr = pick_target();
                restart(branch_addr);
            end
        end
        freeze = ($urandom_range(99) < fz_pct);
        topup();
    endtask

    // Monitor: sample on negedge, compare consumed heads.
    logic        prev_rst = 1'b1;
    logic        prev_branch = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("req_in_rst", {31'b0, bus.imem_req}, 32'd0);
        end else begin
            if (prev_rst) begin
                chk("rst_valid", {31'b0, out_valid}, 32'd0);
                chk("rst_pc", out_pc, 32'h0);
                chk("rst_instr", out_instr, 32'h0);
                chk("rst_req", {31'b0, bus.imem_req}, 32'd1);
                chk("rst_addr", bus.imem_addr, RPC);
            end
            if (prev_branch) begin
                chk("valid_after_branch", {31'b0, out_valid}, 32'd0);
            end
            if (prev_req && !prev_ready && !prev_rst) begin
                chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
                chk("addr_hold", bus.imem_addr, prev_addr);
            end
            if (full_rate) begin
                chk("full_rate", {31'b0, out_valid}, 32'd1);
            end
            if (out_valid && !freeze && !branch_taken) begin
                consumed++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got pc %h expected none",
                             out_pc);
                end else begin
                    e = sb.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.ins);
                end
            end
        end
        prev_rst    = rst;
        prev_branch = branch_taken && !rst;
        prev_req    = bus.imem_req;
        prev_ready  = bus.imem_ready;
        prev_addr   = bus.imem_addr;
    end

    initial begin
        rst            = 1'b1;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_addr    = 32'h0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        wmax = 0; fz_pct = 0; br_pct = 0; rst_pct = 0;
        rst_left = 2; wl = 0; full_rate = 1'b0;
        restart(RPC);

        repeat (6) cycle();
        full_rate = 1'b1;
        repeat (20) cycle();
        full_rate = 1'b0;

        fz_pct = 100;
        repeat (4) cycle();
        fz_pct = 0;
        repeat (10) cycle();

        wmax = 3; fz_pct = 30; br_pct = 10;
        repeat (1500) cycle();

        rst_pct = 2;
        repeat (1000) cycle();

        rst_pct = 0; wmax = 0; fz_pct = 50; br_pct = 15;
        repeat (1000) cycle();

        wmax = 2; fz_pct = 10; br_pct = 5;
        repeat (1000) cycle();

        @(negedge clk);
        chk("progress", {31'b0, (consumed > 300)}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
